// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared ALU.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   req0_* / req1_*          - valid/ready request channels (a, b, op)
//   alu_a, alu_b, alu_control - registered operands to the shared ALU
//   alu_result, alu_zero     - combinational ALU outputs
//   rsp_*                    - valid/ready response channel (result, zero, id, err)
module alu_arbiter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [n-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_id,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         last;
    logic         grant;
    logic         any;
    logic         accept;
    logic         unsup;
    logic         id_q;
    logic [n-1:0] a_q;
    logic [n-1:0] b_q;
    logic [3:0]   op_q;

    // Round-robin: on a tie, the requester not served last wins.
    always_comb begin
        any   = req0_valid | req1_valid;
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign accept     = (state == IDLE) && any && !rst;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign unsup       = (op_q >= 4'd13);
    assign rsp_valid   = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            last       <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        a_q  <= grant ? req1_a : req0_a;
                        b_q  <= grant ? req1_b : req0_b;
                        op_q <= grant ? req1_op : req0_op;
                        id_q <= grant;
                    end
                end
                EXEC: begin
                    // Unsupported codes report a forced zero result.
                    rsp_result <= unsup ? '0 : alu_result;
                    rsp_zero   <= unsup ? 1'b1 : alu_zero;
                    rsp_id     <= id_q;
                    rsp_err    <= unsup;
                end
                RESP: begin
                    if (rsp_ready)
                        last <= rsp_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
// Models a small ALU (add/sub/and/or/xor) on the shared ALU port.
module tb_alu_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [3:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [3:0]   req1_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_id;
    logic         rsp_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.n(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err)
    );

    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [N-1:0] obs,
                        input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic rsp_chk(input string tag, input logic [N-1:0] res,
                           input logic z, input logic id, input logic err);
        chk1({tag, "_valid"}, rsp_valid, 1'b1);
        chkw({tag, "_result"}, rsp_result, res);
        chk1({tag, "_zero"}, rsp_zero, z);
        chk1({tag, "_id"}, rsp_id, id);
        chk1({tag, "_err"}, rsp_err, err);
    endtask

    task automatic set0(input logic v, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3:0] op);
        req0_valid = v;
        req0_a     = a;
        req0_b     = b;
        req0_op    = op;
    endtask

    task automatic set1(input logic v, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3:0] op);
        req1_valid = v;
        req1_a     = a;
        req1_b     = b;
        req1_op    = op;
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b0, '0, '0, 4'd0);
        set1(1'b0, '0, '0, 4'd0);

        // Reset: ready held low even with a valid request.
        nxt();
        set0(1'b1, 32'd9, 32'd9, 4'd0);
        #1;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        nxt();
        set0(1'b0, '0, '0, 4'd0);
        #1;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chkw("rst_rsp_result", rsp_result, 32'd0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chkw("rst_alu_a", alu_a, 32'd0);
        chkw("rst_alu_b", alu_b, 32'd0);
        chkw("rst_alu_ctl", {28'd0, alu_control}, 32'd0);

        // Tie after reset: req0 (1+1) first, then req1 (9-4).
        nxt();
        rst = 1'b0;
        set0(1'b1, 32'd1, 32'd1, 4'b0000);
        set1(1'b1, 32'd9, 32'd4, 4'b0001);
        #1;
        chk1("tie1_ready0", req0_ready, 1'b1);
        chk1("tie1_ready1", req1_ready, 1'b0);
        chk1("tie1_idle_rv", rsp_valid, 1'b0);
        nxt();
        set0(1'b0, '0, '0, 4'd0);
        #1;
        chk1("tie1_exec_rv", rsp_valid, 1'b0);
        chk1("tie1_exec_r1", req1_ready, 1'b0);
        chkw("tie1_alu_a", alu_a, 32'd1);
        nxt();
        #1;
        rsp_chk("tie1_rsp", 32'd2, 1'b0, 1'b0, 1'b0);
        chk1("tie1_rsp_r1", req1_ready, 1'b0);
        nxt();
        #1;
        chk1("tie1b_ready1", req1_ready, 1'b1);
        chk1("tie1b_ready0", req0_ready, 1'b0);
        nxt();
        set1(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("tie1b_rsp", 32'd5, 1'b0, 1'b1, 1'b0);

        // Second tie goes to req0 (and); req1 zero-flag sub follows.
        nxt();
        set0(1'b1, 32'hC, 32'hA, 4'b0010);
        set1(1'b1, 32'd7, 32'd7, 4'b0001);
        #1;
        chk1("tie2_ready0", req0_ready, 1'b1);
        chk1("tie2_ready1", req1_ready, 1'b0);
        nxt();
        set0(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("tie2_rsp", 32'd8, 1'b0, 1'b0, 1'b0);
        nxt();
        #1;
        chk1("zero_ready1", req1_ready, 1'b1);
        nxt();
        set1(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("zero_rsp", 32'd0, 1'b1, 1'b1, 1'b0);

        // Backpressure; req1 (unsupported op) arrives during EXEC and waits.
        nxt();
        set0(1'b1, 32'h10, 32'h20, 4'b0000);
        #1;
        chk1("bp_ready0", req0_ready, 1'b1);
        nxt();
        set0(1'b0, '0, '0, 4'd0);
        set1(1'b1, 32'd3, 32'd4, 4'b1111);
        rsp_ready = 1'b0;
        #1;
        chk1("bp_exec_r1", req1_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1;
            rsp_chk("bp_hold", 32'h30, 1'b0, 1'b0, 1'b0);
            chk1("bp_hold_r0", req0_ready, 1'b0);
            chk1("bp_hold_r1", req1_ready, 1'b0);
        end
        nxt();
        rsp_ready = 1'b1;
        #1;
        rsp_chk("bp_release", 32'h30, 1'b0, 1'b0, 1'b0);
        nxt();
        #1;
        chk1("unsup_ready1", req1_ready, 1'b1);
        nxt();
        set1(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("unsup_rsp", 32'd0, 1'b1, 1'b1, 1'b1);

        // req0-only transaction leaves last-grant at 0.
        nxt();
        set0(1'b1, 32'd2, 32'd2, 4'b0000);
        #1;
        chk1("pre_ready0", req0_ready, 1'b1);
        nxt();
        set0(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("pre_rsp", 32'd4, 1'b0, 1'b0, 1'b0);

        // req1 transaction aborted by reset in RESP.
        nxt();
        rsp_ready = 1'b0;
        set1(1'b1, 32'd1, 32'd2, 4'b0000);
        #1;
        chk1("ab_ready1", req1_ready, 1'b1);
        nxt();
        set1(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("ab_rsp", 32'd3, 1'b0, 1'b1, 1'b0);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        rsp_ready = 1'b1;
        set0(1'b1, 32'd6, 32'd1, 4'b0001);
        set1(1'b1, 32'd1, 32'd1, 4'b0000);
        #1;
        chk1("ab_rv_after", rsp_valid, 1'b0);
        chkw("ab_alu_a", alu_a, 32'd0);
        chk1("ab_tie_ready0", req0_ready, 1'b1);
        chk1("ab_tie_ready1", req1_ready, 1'b0);
        nxt();
        set0(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("ab_tie_rsp", 32'd5, 1'b0, 1'b0, 1'b0);
        nxt();
        #1;
        chk1("ab_tie_ready1b", req1_ready, 1'b1);
        nxt();
        set1(1'b0, '0, '0, 4'd0);
        nxt();
        #1;
        rsp_chk("ab_tie_rsp1", 32'd2, 1'b0, 1'b1, 1'b0);
        nxt();
        #1;
        chk1("end_idle_rv", rsp_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
